tns_decoder_12: RTL

// - Receive-side inverse of the 12-wire TNS encoder: maps a 12-bit TNS codeword (4 groups x 3 wires) back to a `BLEN04-bit data word.
// - Sits at the far end of the bus, after the codeword is captured.
// - Output feeds the sink through a 2-stage valid/ready pipeline.
// - Group weights come from TNS.vh, the same macros the encoder uses, so the codec pair stays consistent.

---
 rtl/tns_decoder_12_if.sv | 25 ++
 rtl/tns_decoder_12.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tns_decoder_12_if.sv
// Handshake bundle between the TNS codeword capture stage, the decoder and its sink.
// slave = decoder side, master = upstream/sink driver side.
`ifndef BLEN04
`define BLEN04 8
`endif

interface tns_decoder_12_if #(parameter int DW = `BLEN04) ();
  logic [11:0]   codein;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] dataout;
  logic          valid_out;
  logic          ready_out;
  logic          err_out;

  modport slave (
    input  codein, valid_in, ready_out,
    output ready_in, dataout, valid_out, err_out
  );

  modport master (
    output codein, valid_in, ready_out,
    input  ready_in, dataout, valid_out, err_out
  );
endinterface

// File: rtl/tns_decoder_12.sv
// TNS 12-wire decoder: weighted-sum codeword to data word through a 2-stage valid/ready pipe.
// Optional range check on the sum is enabled with `define TNS_DEC_RANGE_CHK_EN.
`ifndef BLEN04
`define BLEN04 8
`endif
`ifndef TNS04_A
`define TNS04_A 192
`define TNS04_B 128
`define TNS04_C 64
`define TNS03_A 48
`define TNS03_B 32
`define TNS03_C 16
`define TNS02_A 12
`define TNS02_B 8
`define TNS02_C 4
`define TNS01_A 3
`define TNS01_B 2
`define TNS01_C 1
`endif

module tns_decoder_12 #(
  parameter int DW   = `BLEN04,
  parameter int SKID = 1
) (
  input  logic           clock,
  input  logic           rst_n,
  tns_decoder_12_if.slave bus
);

`ifdef TNS_DEC_RANGE_CHK_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif

  function automatic logic [SW-1:0] grp_w(input logic [2:0] g, input int wa, input int wb,
                                          input int wc);
    logic [SW-1:0] r;
    r = '0;
    if (g[2]) r = r + SW'(wa);
    if (g[1]) r = r + SW'(wb);
    if (g[0]) r = r + SW'(wc);
    return r;
  endfunction

  logic          s1v;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          adv2;
  logic          s1_ready;
  logic          acc;
  logic          s1_load;
  logic [11:0]   s1_code;
  logic [SW-1:0] hi, lo, hi_d, lo_d, sum;

  assign adv2     = ~valid_q | bus.ready_out;
  assign s1_ready = ~s1v | adv2;
  assign acc      = bus.valid_in & bus.ready_in;

  generate
    if (SKID != 0) begin : g_skid
      logic        skid_v;
      logic        skid_v_nxt;
      logic [11:0] skid_code;
      logic        rdy_q;

      // A word accepted while stage 1 cannot move parks here; ready drops a cycle later.
      always_comb begin
        skid_v_nxt = skid_v;
        if (skid_v) skid_v_nxt = ~s1_ready;
        else        skid_v_nxt = acc & ~s1_ready;
      end

      assign s1_load      = s1_ready & (skid_v | acc);
      assign s1_code      = skid_v ? skid_code : bus.codein;
      assign bus.ready_in = rdy_q;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          skid_v    <= 1'b0;
          skid_code <= '0;
          rdy_q     <= 1'b1;
        end else begin
          skid_v <= skid_v_nxt;
          rdy_q  <= ~skid_v_nxt;
          if (acc & ~skid_v & ~s1_ready) skid_code <= bus.codein;
        end
      end
    end else begin : g_noskid
      assign s1_load      = acc;
      assign s1_code      = bus.codein;
      assign bus.ready_in = s1_ready;
    end
  endgenerate

  always_comb begin
    hi_d = grp_w(s1_code[11:9], `TNS04_A, `TNS04_B, `TNS04_C)
         + grp_w(s1_code[8:6],  `TNS03_A, `TNS03_B, `TNS03_C);
    // The encoder sends the grp1 remainder raw, so bit 0 always weighs 1.
    lo_d = grp_w(s1_code[5:3], `TNS02_A, `TNS02_B, `TNS02_C)
         + grp_w({s1_code[2:1], 1'b0}, `TNS01_A, `TNS01_B, 0)
         + {{(SW-1){1'b0}}, s1_code[0]};
  end

  assign sum = hi + lo;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1v <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else if (s1_load) begin
      s1v <= 1'b1;
      hi  <= hi_d;
      lo  <= lo_d;
    end else if (adv2) begin
      s1v <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv2) begin
      valid_q <= s1v;
      if (s1v) data_q <= sum[DW-1:0];
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.dataout   = data_q;

`ifdef TNS_DEC_RANGE_CHK_EN
  logic err_q;

  // With SW = DW+1 the sum cannot reach 2**DW in its low bits, so the carry alone flags overflow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)            err_q <= 1'b0;
    else if (adv2 && s1v)  err_q <= sum[DW];
  end

  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif

endmodule
